// File: rtl/axi_rd_arbiter_if.sv
// rtl/axi_rd_arbiter_if.sv - AR/R bus bundle between two read masters, the arbiter and DDR
interface axi_rd_arbiter_if #(
    parameter int ADDR_BITS       = 16,
    parameter int TID_WIDTH       = 8,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int LOG_MAX_OUT     = 3
);
    // requester-side AR channels
    logic                       s0_ar_valid;
    logic                       s0_ar_ready;
    logic [ADDR_BITS-1:0]       s0_ar_addr;
    logic [BURST_LEN_WIDTH-1:0] s0_ar_len;
    logic [TID_WIDTH-1:0]       s0_ar_id;
    logic                       s1_ar_valid;
    logic                       s1_ar_ready;
    logic [ADDR_BITS-1:0]       s1_ar_addr;
    logic [BURST_LEN_WIDTH-1:0] s1_ar_len;
    logic [TID_WIDTH-1:0]       s1_ar_id;
    // DDR-side AR channel
    logic                       m_ar_valid;
    logic                       m_ar_ready;
    logic [ADDR_BITS-1:0]       m_ar_addr;
    logic [BURST_LEN_WIDTH-1:0] m_ar_len;
    logic [TID_WIDTH:0]         m_ar_id;
    // DDR-side R channel
    logic                       m_r_valid;
    logic                       m_r_ready;
    logic                       m_r_last;
    logic [DATA_WIDTH-1:0]      m_r_data;
    logic [TID_WIDTH:0]         m_r_id;
    // requester-side R channels
    logic                       s0_r_valid;
    logic                       s0_r_ready;
    logic                       s0_r_last;
    logic [DATA_WIDTH-1:0]      s0_r_data;
    logic [TID_WIDTH-1:0]       s0_r_id;
    logic                       s1_r_valid;
    logic                       s1_r_ready;
    logic                       s1_r_last;
    logic [DATA_WIDTH-1:0]      s1_r_data;
    logic [TID_WIDTH-1:0]       s1_r_id;
    // control and status
    logic [LOG_MAX_OUT:0]       outLimit;
    logic                       drain;
    logic                       idle;
    logic                       errorStrb;

    // arbiter view
    modport slave (
        input  s0_ar_valid, s0_ar_addr, s0_ar_len, s0_ar_id,
        input  s1_ar_valid, s1_ar_addr, s1_ar_len, s1_ar_id,
        output s0_ar_ready, s1_ar_ready,
        output m_ar_valid, m_ar_addr, m_ar_len, m_ar_id,
        input  m_ar_ready,
        input  m_r_valid, m_r_last, m_r_data, m_r_id,
        output m_r_ready,
        output s0_r_valid, s0_r_last, s0_r_data, s0_r_id,
        output s1_r_valid, s1_r_last, s1_r_data, s1_r_id,
        input  s0_r_ready, s1_r_ready,
        input  outLimit, drain,
        output idle, errorStrb
    );

    // environment view (requesters, DDR and control all driven from outside the arbiter)
    modport master (
        output s0_ar_valid, s0_ar_addr, s0_ar_len, s0_ar_id,
        output s1_ar_valid, s1_ar_addr, s1_ar_len, s1_ar_id,
        input  s0_ar_ready, s1_ar_ready,
        input  m_ar_valid, m_ar_addr, m_ar_len, m_ar_id,
        output m_ar_ready,
        output m_r_valid, m_r_last, m_r_data, m_r_id,
        input  m_r_ready,
        input  s0_r_valid, s0_r_last, s0_r_data, s0_r_id,
        input  s1_r_valid, s1_r_last, s1_r_data, s1_r_id,
        output s0_r_ready, s1_r_ready,
        output outLimit, drain,
        input  idle, errorStrb
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - two-master round-robin AXI read arbiter with ID tagging and outstanding limits
module axi_rd_arbiter #(
    parameter int ADDR_BITS       = 16,
    parameter int TID_WIDTH       = 8,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int LOG_MAX_OUT     = 3
) (
    input  logic             clk,
    input  logic             resetN,
    axi_rd_arbiter_if.slave  bus
);
    localparam int CNT_W = LOG_MAX_OUT + 1;

    typedef enum logic {
        ARB   = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic                       rr_q;
    logic [CNT_W-1:0]           cnt0_q, cnt0_d;
    logic [CNT_W-1:0]           cnt1_q, cnt1_d;
    logic [ADDR_BITS-1:0]       addr_q;
    logic [BURST_LEN_WIDTH-1:0] len_q;
    logic [TID_WIDTH:0]         id_q;
    logic                       err_q, err_d;

    logic                       elig0, elig1;
    logic                       grant_vld;
    logic                       grant_sel;
    logic                       r_port;
    logic                       r_ready;
    logic                       r_last_fire;
    logic                       inc0, inc1, dec0, dec1;
    logic [DATA_WIDTH-1:0]      r_data;

    assign elig0 = bus.s0_ar_valid && (cnt0_q < bus.outLimit) && !bus.drain;
    assign elig1 = bus.s1_ar_valid && (cnt1_q < bus.outLimit) && !bus.drain;

    // grant selection: rr_q names the preferred port only when both compete
    always_comb begin
        grant_vld = (state_q == ARB) && (elig0 || elig1);
        grant_sel = (elig0 && elig1) ? rr_q : elig1;
    end

    assign bus.s0_ar_ready = grant_vld && !grant_sel;
    assign bus.s1_ar_ready = grant_vld && grant_sel;

    // state register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // next state: one grant moves to ISSUE, DDR handshake returns to ARB
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:     if (grant_vld)      state_d = ISSUE;
            ISSUE:   if (bus.m_ar_ready) state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    // outputs derived from registered state
    always_comb begin
        bus.m_ar_valid = (state_q == ISSUE);
        bus.idle       = (state_q == ARB) && (cnt0_q == '0) && (cnt1_q == '0);
    end

    assign bus.m_ar_addr = addr_q;
    assign bus.m_ar_len  = len_q;
    assign bus.m_ar_id   = id_q;

    // R routing: the tag bit picks the port, and that port's ready throttles DDR directly
    assign r_port      = bus.m_r_id[TID_WIDTH];
    assign r_ready     = r_port ? bus.s1_r_ready : bus.s0_r_ready;
    assign r_last_fire = bus.m_r_valid && r_ready && bus.m_r_last;
    assign r_data      = bus.m_r_data;

    assign bus.m_r_ready  = r_ready;
    assign bus.s0_r_valid = bus.m_r_valid && !r_port;
    assign bus.s1_r_valid = bus.m_r_valid && r_port;
    assign bus.s0_r_last  = bus.m_r_last;
    assign bus.s1_r_last  = bus.m_r_last;
    assign bus.s0_r_data  = r_data;
    assign bus.s1_r_data  = r_data;
    assign bus.s0_r_id    = bus.m_r_id[TID_WIDTH-1:0];
    assign bus.s1_r_id    = bus.m_r_id[TID_WIDTH-1:0];

    assign inc0 = grant_vld && !grant_sel;
    assign inc1 = grant_vld && grant_sel;
    assign dec0 = r_last_fire && !r_port;
    assign dec1 = r_last_fire && r_port;

    // outstanding counters saturate at zero; a last with nothing outstanding flags an error
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        err_d  = err_q;
        if (inc0 && !dec0) begin
            cnt0_d = cnt0_q + CNT_W'(1);
        end else if (dec0 && !inc0 && (cnt0_q != '0)) begin
            cnt0_d = cnt0_q - CNT_W'(1);
        end
        if (inc1 && !dec1) begin
            cnt1_d = cnt1_q + CNT_W'(1);
        end else if (dec1 && !inc1 && (cnt1_q != '0)) begin
            cnt1_d = cnt1_q - CNT_W'(1);
        end
        if ((dec0 && (cnt0_q == '0)) || (dec1 && (cnt1_q == '0))) begin
            err_d = 1'b1;
        end
    end

    // counters, error flag, rr pointer and the AR holding register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rr_q   <= 1'b0;
            cnt0_q <= '0;
            cnt1_q <= '0;
            err_q  <= 1'b0;
            addr_q <= '0;
            len_q  <= '0;
            id_q   <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
            err_q  <= err_d;
            if (grant_vld) begin
                rr_q   <= !grant_sel;
                addr_q <= grant_sel ? bus.s1_ar_addr : bus.s0_ar_addr;
                len_q  <= grant_sel ? bus.s1_ar_len : bus.s0_ar_len;
                id_q   <= {grant_sel, (grant_sel ? bus.s1_ar_id : bus.s0_ar_id)};
            end
        end
    end

    assign bus.errorStrb = err_q;
endmodule
